// File: rtl/hamming_pkg.sv
// Shared constants and types for the (16,11) extended Hamming stream encoder.
// HAM_DATA_POS lists the codeword position of each data bit, d[0] first.
package hamming_pkg;

  localparam int HAM_DATA_W = 11;
  localparam int HAM_CODE_W = 16;

  typedef logic [HAM_CODE_W-1:0] ham_code_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ham_state_t;

  localparam logic [HAM_DATA_W-1:0][3:0] HAM_DATA_POS = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd3
  };

  // Positions 3..15 covered by parity bits 1, 2, 4 and 8 respectively.
  localparam logic [3:0][HAM_CODE_W-1:0] HAM_PAR_MASK = {
    16'hFE00, 16'hF0E0, 16'hCCC8, 16'hAAA8
  };

endpackage

// File: rtl/hamming_enc16.sv
// Combinational (16,11) SECDED encoder: zero latency, no flow control.
// Parity slots 0,1,2,4,8 are left zero in the placed word and filled afterwards.
module hamming_enc16
  import hamming_pkg::*;
(
  input  logic [HAM_DATA_W-1:0] data_i,
  output ham_code_t             code_o
);

  ham_code_t  placed;
  logic [3:0] par;
  logic       par_all;

  assign placed[0] = 1'b0;
  assign placed[1] = 1'b0;
  assign placed[2] = 1'b0;
  assign placed[4] = 1'b0;
  assign placed[8] = 1'b0;

  for (genvar i = 0; i < HAM_DATA_W; i++) begin : g_place
    assign placed[HAM_DATA_POS[i]] = data_i[i];
  end

  for (genvar p = 0; p < 4; p++) begin : g_par
    assign par[p] = ^(placed & HAM_PAR_MASK[p]);
  end

  assign par_all = (^placed) ^ (^par);

  assign code_o = placed | {7'b0, par[3], 3'b0, par[2], 1'b0, par[1], par[0], par_all};

endmodule

// File: rtl/hamming_stream_enc.sv
// Splits a BLOCKS*11-bit word into LANES codewords per beat; first beat valid the cycle after accept.
// Valid/ready: one word in flight, in_ready only when idle; optional HAMMING_ERR_INJECT_EN flips a lane-0 bit.
module hamming_stream_enc
  import hamming_pkg::*;
#(
  parameter int BLOCKS = 8,
  parameter int LANES  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BLOCKS*HAM_DATA_W-1:0] in_data,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic                         err_inj,
  input  logic [3:0]                   err_inj_pos,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*HAM_CODE_W-1:0]  out_data,
  output logic                         out_last
);

  localparam int NBEATS = BLOCKS / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (BLOCKS < 1 || LANES < 1 || (BLOCKS % LANES) != 0) begin : g_bad_cfg
    $error("hamming_stream_enc: BLOCKS must be >= 1 and a multiple of LANES");
  end

  ham_state_t                      state_q, state_d;
  logic [BEAT_W-1:0]               beat_q, beat_d, sel_beat;
  logic [BLOCKS*HAM_DATA_W-1:0]    word_q, word_d, sel_word;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic [LANES*HAM_CODE_W-1:0]     out_data_q, out_data_d;
  logic [LANES*HAM_CODE_W-1:0]     enc_flat, enc_beat;
  logic [NBEATS-1:0][LANES*HAM_DATA_W-1:0] beat_view;
  logic [LANES*HAM_DATA_W-1:0]     sel_blocks;

  // Encoders always look one beat ahead so out_data can be registered.
  assign sel_word   = (state_q == IDLE) ? in_data : word_q;
  assign sel_beat   = (state_q == IDLE) ? '0 : beat_q + BEAT_W'(1);
  assign beat_view  = sel_word;
  assign sel_blocks = beat_view[sel_beat];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    hamming_enc16 u_enc (
      .data_i (sel_blocks[j*HAM_DATA_W +: HAM_DATA_W]),
      .code_o (enc_flat[j*HAM_CODE_W +: HAM_CODE_W])
    );
  end

`ifdef HAMMING_ERR_INJECT_EN
  logic       inj_q, inj_d, inj_sel;
  logic [3:0] inj_pos_q, inj_pos_d, pos_sel;

  assign inj_sel = (state_q == IDLE) ? err_inj     : inj_q;
  assign pos_sel = (state_q == IDLE) ? err_inj_pos : inj_pos_q;

  always_comb begin
    enc_beat = enc_flat;
    if (inj_sel) begin
      enc_beat[HAM_CODE_W-1:0] = enc_flat[HAM_CODE_W-1:0] ^ (16'h0001 << pos_sel);
    end
  end
`else
  assign enc_beat = enc_flat;
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
`ifdef HAMMING_ERR_INJECT_EN
    inj_d       = inj_q;
    inj_pos_d   = inj_pos_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = BUSY;
          beat_d      = '0;
          word_d      = in_data;
          out_valid_d = 1'b1;
          out_last_d  = (LAST_BEAT == '0);
          out_data_d  = enc_beat;
`ifdef HAMMING_ERR_INJECT_EN
          inj_d       = err_inj;
          inj_pos_d   = err_inj_pos;
`endif
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            beat_d     = sel_beat;
            out_last_d = (sel_beat == LAST_BEAT);
            out_data_d = enc_beat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
`ifdef HAMMING_ERR_INJECT_EN
      inj_q       <= 1'b0;
      inj_pos_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
`ifdef HAMMING_ERR_INJECT_EN
      inj_q       <= inj_d;
      inj_pos_q   <= inj_pos_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_hamming_stream_enc.sv
// Bench for hamming_stream_enc (BLOCKS=8, LANES=2): constant vector table, hand sequences, random words vs model.
module tb_hamming_stream_enc;

  localparam int BLOCKS = 8;
  localparam int LANES  = 2;
  localparam int NB     = BLOCKS / LANES;
  localparam int DW     = BLOCKS * 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
`ifdef HAMMING_ERR_INJECT_EN
  logic          err_inj;
  logic [3:0]    err_inj_pos;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hamming_stream_enc #(.BLOCKS(BLOCKS), .LANES(LANES)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
`ifdef HAMMING_ERR_INJECT_EN
    .err_inj     (err_inj),
    .err_inj_pos (err_inj_pos),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  typedef struct {
    logic [DW-1:0]        data;
    logic [NB-1:0][31:0]  exp;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: walk codeword positions 1..15, data fills non-powers of two in order.
  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic [15:0] c;
    logic        x;
    int          k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) x = x ^ c[pos];
      c[p] = x;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [NB-1:0][31:0] ref_word(input logic [DW-1:0] w);
    logic [NB-1:0][31:0] r;
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < LANES; j++)
        r[b][j*16 +: 16] = ref_enc(w[(b*LANES + j)*11 +: 11]);
    return r;
  endfunction

  task automatic send(input logic [DW-1:0] w, input logic inj, input logic [3:0] pos);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = w;
`ifdef HAMMING_ERR_INJECT_EN
    err_inj     = inj;
    err_inj_pos = pos;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom};
`ifdef HAMMING_ERR_INJECT_EN
    err_inj     = ~inj;
    err_inj_pos = ~pos;
`else
    if (inj || pos != 4'd0) $display("note: error injection not built in");
`endif
  endtask

  // mode 0: ready always; 1: stall stall_n cycles in stall_beat; 2: random ready.
  task automatic collect(input logic [NB-1:0][31:0] exp, input int mode, input int stall_beat,
                         input int stall_n, input int stop_beat, input string tag);
    int   b = 0;
    int   stalls = 0;
    int   cyc = 0;
    logic hs;
    while (b < NB && b != stop_beat && cyc < 100) begin
      check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
      check({tag, "_data"}, {32'b0, out_data}, {32'b0, exp[b]});
      check({tag, "_last"}, {63'b0, out_last}, {63'b0, (b == NB - 1)});
      check({tag, "_in_ready_busy"}, {63'b0, in_ready}, 64'd0);
      case (mode)
        1: begin
          if (b == stall_beat && stalls < stall_n) begin
            out_ready = 1'b0;
            stalls++;
          end else out_ready = 1'b1;
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) b++;
    end
    if (cyc >= 100) check({tag, "_timeout"}, 64'd1, 64'd0);
    out_ready = 1'b1;
    if (stop_beat >= NB) begin
      check({tag, "_done_valid"}, {63'b0, out_valid}, 64'd0);
      check({tag, "_done_in_ready"}, {63'b0, in_ready}, 64'd1);
    end
  endtask

  initial begin
    logic [DW-1:0]       w;
    logic [NB-1:0][31:0] e;

    tbl[0].data = '0;
    tbl[0].exp  = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[1].data = '1;
    tbl[1].exp  = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[2].data = '0;
    tbl[2].data[10:0] = 11'h001;
    tbl[2].exp  = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_000F};
    tbl[3].data = '0;
    tbl[3].data[21:11] = 11'h001;
    tbl[3].exp  = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h000F_0000};
    tbl[4].data = '0;
    tbl[4].data[87:77] = 11'h001;
    tbl[4].exp  = {32'h000F_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
    err_inj     = 1'b0;
    err_inj_pos = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_last",  {63'b0, out_last},  64'd0);
    check("rst_out_data",  {32'b0, out_data},  64'd0);
    check("rst_in_ready",  {63'b0, in_ready},  64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, 1'b0, 4'd0);
      collect(tbl[i].exp, 0, 0, 0, NB, $sformatf("tbl%0d", i));
    end

    // Stall three cycles in beat 1.
    w = {$urandom, $urandom, $urandom};
    send(w, 1'b0, 4'd0);
    collect(ref_word(w), 1, 1, 3, NB, "stall");

    // Reset during beat 2, then a fresh word must start at beat 0.
    w = {$urandom, $urandom, $urandom};
    send(w, 1'b0, 4'd0);
    collect(ref_word(w), 0, 0, 0, 2, "pre_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_in_ready",  {63'b0, in_ready},  64'd1);
    check("midrst_out_last",  {63'b0, out_last},  64'd0);
    check("midrst_out_data",  {32'b0, out_data},  64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_beats", {63'b0, out_valid}, 64'd0);
    end
    w = {$urandom, $urandom, $urandom};
    send(w, 1'b0, 4'd0);
    collect(ref_word(w), 0, 0, 0, NB, "post_rst");

    for (int n = 0; n < 25; n++) begin
      w = {$urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(w, 1'b0, 4'd0);
      collect(ref_word(w), 2, 0, 0, NB, "rand");
    end

`ifdef HAMMING_ERR_INJECT_EN
    w = '0;
    w[10:0] = 11'h001;
    e = {32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_800F};
    send(w, 1'b1, 4'd15);
    collect(e, 0, 0, 0, NB, "inj");
    send(w, 1'b0, 4'd15);
    collect(tbl[2].exp, 0, 0, 0, NB, "no_inj");
`else
    e = '0;
    if (e != '0) $display("unexpected");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
